seq_shift_reg: RTL and testbench
================================

SEQ_SHIFT_REG -- requirements
Module: seq_shift_reg

Interface
REQ-001 SHALL have parameter N, default 16, meaning register width; legal range N >= 2.
REQ-002 SHALL have parameter AW, default $clog2(N), meaning shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous clear.
REQ-006 SHALL have port load, input, 1, parallel load of Din.
REQ-007 SHALL have port Din, input, N, parallel data in.
REQ-008 SHALL have port start, input, 1, request for a multi-cycle shift operation.
REQ-009 SHALL have port mode, input, 3, operation select: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; 5-7 reserved.
REQ-010 SHALL have port amt, input, AW, number of single-position shifts, 0..N-1.
REQ-011 SHALL have port shiftin, input, 1, fill bit for SLL/SRL, sampled every shift cycle.
REQ-012 SHALL have port Dout, output, N, register contents.
REQ-013 SHALL have port sout, output, 1, last bit shifted or rotated out.
REQ-014 SHALL have port busy, output, 1, high while in SHIFT.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE and SHIFT.
REQ-017 Per-edge priority SHALL be: clear, then load, then start, then shift step, then hold.
REQ-018 clear SHALL set Dout=0 and sout=0, force IDLE, and suppress done, in any state.
REQ-019 load SHALL set Dout=Din and force IDLE without done, in any state; an in-progress shift is aborted.
REQ-020 In IDLE, start with a legal mode and amt!=0 SHALL latch mode and amt, set count=amt, and enter SHIFT; Dout does not change on this edge.
REQ-021 In IDLE, start with amt==0 and a legal mode SHALL leave Dout unchanged, stay in IDLE, and pulse done on the next edge.
REQ-022 start with reserved mode SHALL be ignored: no state change, no done.
REQ-023 start while in SHIFT SHALL be ignored.
REQ-024 Each SHIFT cycle SHALL shift one position per the latched mode and decrement count.
- SLL: {Dout[N-2:0],shiftin}, sout=Dout[N-1].
- SRL: {shiftin,Dout[N-1:1]}, sout=Dout[0].
- SRA: {Dout[N-1],Dout[N-1:1]}, sout=Dout[0].
- ROL and ROR: rotate by one; sout = the wrapped bit.
REQ-025 On the shift edge where count reaches 0, the FSM SHALL return to IDLE and done SHALL be 1 for exactly that following cycle, concurrent with the final Dout.
REQ-026 busy SHALL be high for exactly amt cycles per operation.
REQ-027 Latched mode and amt SHALL be unaffected by input changes during SHIFT.
REQ-028 In IDLE without a command, Dout and sout SHALL hold.

Reset
REQ-029 rst_n low SHALL asynchronously set Dout=0, sout=0, busy=0, done=0, count=0, and state=IDLE, including mid-operation.
REQ-030 After rst_n rises, the first edge SHALL obey REQ-017 normally.

Structure
REQ-031 The mode encoding typedef and the constants SLL/SRL/SRA/ROL/ROR SHALL reside in shared package shift_pkg.
REQ-032 The single-position combinational shifter SHALL be sub-module shift_step (inputs data, mode, shiftin; outputs next data, out bit).
REQ-033 The FSM, count, and output registers SHALL reside in seq_shift_reg.

Verification
REQ-034 Bench SHALL cover: load 16'hA5C3, start SLL amt=4 shiftin=0 -> busy 4 cycles, then Dout=16'h5C30, done one cycle, sout=0.
REQ-035 Bench SHALL cover: load 16'h8001, start SRA amt=3 -> Dout=16'hF000, sout=0, done one cycle.
REQ-036 Bench SHALL cover: load 16'h0001, start ROL amt=15 -> Dout=16'h8000 after 15 busy cycles; ROR amt=1 then -> Dout=16'h4000.
REQ-037 Bench SHALL cover: SRL amt=8 on 16'hFFFF with clear asserted at the 3rd busy cycle -> Dout=0, busy=0, done never asserted.
REQ-038 Bench SHALL cover: start amt=0 -> done next cycle with Dout unchanged; start during SHIFT and start with mode=6 -> ignored.
REQ-039 Bench SHALL cover: rst_n pulsed low between edges mid-SHIFT -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the sequential shift register.
//               - shift_mode_e : operation select (SLL/SRL/SRA/ROL/ROR).
//               - state_e      : controller states (IDLE/SHIFT).
//               - mode_is_legal: rejects the reserved encodings 5..7.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int MODE_W = 3;

  // Operation select. Encodings 5..7 are reserved and never latched.
  typedef enum logic [MODE_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // True for the five defined operations only.
  function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
    return (m <= MODE_W'(ROR));
  endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/seq_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_reg_if
// Description : Command/status bundle of the sequential shift register.
//   Commands (master -> slave):
//     clear   - synchronous clear
//     load    - parallel load of Din
//     Din     - parallel data in, N bits
//     start   - request a multi-cycle shift
//     mode    - operation select (see shift_pkg::shift_mode_e)
//     amt     - number of single-position shifts, AW bits
//     shiftin - fill bit for SLL/SRL, sampled every shift cycle
//   Status (slave -> master):
//     Dout    - register contents
//     sout    - last bit shifted or rotated out
//     busy    - high while shifting
//     done    - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_shift_reg_if #(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
);

  logic                        clear;
  logic                        load;
  logic [N-1:0]                Din;
  logic                        start;
  logic [shift_pkg::MODE_W-1:0] mode;
  logic [AW-1:0]               amt;
  logic                        shiftin;
  logic [N-1:0]                Dout;
  logic                        sout;
  logic                        busy;
  logic                        done;

  // Issues commands and observes status.
  modport master (
    output clear, load, Din, start, mode, amt, shiftin,
    input  Dout, sout, busy, done
  );

  // The shift register itself.
  modport slave (
    input  clear, load, Din, start, mode, amt, shiftin,
    output Dout, sout, busy, done
  );

endinterface : seq_shift_reg_if
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Purely combinational single-position shifter/rotator.
//   Ports:
//     data_i    - current register value, N bits
//     mode_i    - operation select
//     shiftin_i - fill bit used by SLL and SRL
//     data_o    - value after one shift/rotate step
//     out_o     - bit that left the register (the wrapped bit for rotates)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] data_i,
  input  shift_mode_e  mode_i,
  input  logic         shiftin_i,
  output logic [N-1:0] data_o,
  output logic         out_o
);

  always_comb begin
    data_o = data_i;
    out_o  = 1'b0;
    case (mode_i)
      SLL: begin
        data_o = {data_i[N-2:0], shiftin_i};
        out_o  = data_i[N-1];
      end
      SRL: begin
        data_o = {shiftin_i, data_i[N-1:1]};
        out_o  = data_i[0];
      end
      SRA: begin
        // Sign bit is replicated into the vacated MSB.
        data_o = {data_i[N-1], data_i[N-1:1]};
        out_o  = data_i[0];
      end
      ROL: begin
        data_o = {data_i[N-2:0], data_i[N-1]};
        out_o  = data_i[N-1];
      end
      ROR: begin
        data_o = {data_i[0], data_i[N-1:1]};
        out_o  = data_i[0];
      end
      // Reserved encodings are never latched by the controller; hold.
      default: begin
        data_o = data_i;
        out_o  = 1'b0;
      end
    endcase
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/seq_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_reg
// Description : N-bit register that performs a multi-cycle shift/rotate, one
//               position per clock, on request. Per-edge priority is
//               clear > load > start > shift step > hold.
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - command/status bundle (seq_shift_reg_if.slave):
//             clear, load, Din, start, mode, amt, shiftin in;
//             Dout, sout, busy, done out
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_reg
  import shift_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_shift_reg_if.slave  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  shift_mode_e   mode_q,  mode_d;
  logic [N-1:0]  dout_q,  dout_d;
  logic          sout_q,  sout_d;
  logic          done_q,  done_d;

  logic [N-1:0]  step_data;
  logic          step_out;

  // One-position shifter driven by the latched mode, so input changes on
  // mode during an operation have no effect.
  shift_step #(
    .N (N)
  ) u_shift_step (
    .data_i    (dout_q),
    .mode_i    (mode_q),
    .shiftin_i (bus.shiftin),
    .data_o    (step_data),
    .out_o     (step_out)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= SLL;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    done_d  = 1'b0;     // done is a single-cycle pulse

    if (bus.clear) begin
      dout_d  = '0;
      sout_d  = 1'b0;
      count_d = '0;
      state_d = IDLE;
    end else if (bus.load) begin
      // Aborts any shift in progress; sout keeps its last value.
      dout_d  = bus.Din;
      count_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && mode_is_legal(bus.mode)) begin
            if (bus.amt == '0) begin
              // Zero-length operation completes immediately.
              done_d = 1'b1;
            end else begin
              mode_d  = shift_mode_e'(bus.mode);
              count_d = bus.amt;
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          // start is ignored here; one position per cycle.
          dout_d  = step_data;
          sout_d  = step_out;
          count_d = count_q - AW'(1);
          if (count_q == AW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.Dout = dout_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;

endmodule : seq_shift_reg
`default_nettype wire

// File: tb/tb_seq_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_reg
// Description : Self-checking bench for seq_shift_reg (N=16). A behavioural
//               model tracks the expected outputs; a compare process checks
//               every cycle, and directed scenarios pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_reg;
  import shift_pkg::*;

  localparam int N  = 16;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_shift_reg_if #(.N(N), .AW(AW)) bus ();

  seq_shift_reg #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [15:0] m_dout;
  logic        m_sout;
  logic        m_done;
  int          m_rem;
  logic [2:0]  m_mode;

  // Returns {out_bit, new_value} for one step of the given operation.
  function automatic logic [16:0] ref_shift(input logic [2:0] md,
                                            input logic [15:0] d,
                                            input logic si);
    logic [15:0] nd;
    logic        ob;
    nd = d;
    ob = 1'b0;
    case (md)
      3'd0: begin nd = 16'(d << 1) | 16'(si);          ob = d[15]; end
      3'd1: begin nd = (d >> 1) | (si ? 16'h8000 : 16'h0); ob = d[0]; end
      3'd2: begin nd = 16'($signed(d) >>> 1);           ob = d[0];  end
      3'd3: begin nd = 16'(d << 1) | (d >> 15);         ob = d[15]; end
      3'd4: begin nd = (d >> 1) | 16'(d << 15);         ob = d[0];  end
      default: begin nd = d; ob = 1'b0; end
    endcase
    return {ob, nd};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dout <= '0;
      m_sout <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_mode <= 3'd0;
    end else begin
      m_done <= 1'b0;
      if (bus.clear) begin
        m_dout <= '0;
        m_sout <= 1'b0;
        m_rem  <= 0;
      end else if (bus.load) begin
        m_dout <= bus.Din;
        m_rem  <= 0;
      end else if (m_rem == 0) begin
        if (bus.start && bus.mode <= 3'd4) begin
          if (bus.amt == 0) begin
            m_done <= 1'b1;
          end else begin
            m_rem  <= int'(bus.amt);
            m_mode <= bus.mode;
          end
        end
      end else begin
        {m_sout, m_dout} <= ref_shift(m_mode, m_dout, bus.shiftin);
        m_rem  <= m_rem - 1;
        m_done <= (m_rem == 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_dout", 32'(bus.Dout), 32'(m_dout));
      chk("cmp_sout", 32'(bus.sout), 32'(m_sout));
      chk("cmp_busy", 32'(bus.busy), 32'(m_rem != 0));
      chk("cmp_done", 32'(bus.done), 32'(m_done));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 3 time units after the rising edge)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1;
    bus.Din  = v;
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] m, input logic [3:0] a,
                          input logic si);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.amt     = a;
    bus.shiftin = si;
    step();
    bus.start   = 1'b0;
  endtask

  // Counts busy cycles until busy drops, bounded by maxc.
  task automatic run_to_end(input int maxc, output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < maxc) begin
      cyc++;
      step();
    end
    chk("busy_timeout", 32'(bus.busy), 32'(0));
  endtask

  int c;
  int dn;
  int r;

  initial begin
    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.load    = 1'b0;
    bus.Din     = '0;
    bus.start   = 1'b0;
    bus.mode    = 3'd0;
    bus.amt     = '0;
    bus.shiftin = 1'b0;

    step();
    step();
    chk("rst_dout", 32'(bus.Dout), 32'h0);
    chk("rst_sout", 32'(bus.sout), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    step();

    // SLL by 4 with zero fill
    do_load(16'hA5C3);
    do_start(3'd0, 4'd4, 1'b0);
    run_to_end(20, c);
    chk("sll_cycles", 32'(c), 32'd4);
    chk("sll_dout", 32'(bus.Dout), 32'h5C30);
    chk("sll_sout", 32'(bus.sout), 32'h0);
    chk("sll_done", 32'(bus.done), 32'h1);
    step();
    chk("sll_done_pulse", 32'(bus.done), 32'h0);

    // SRA by 3 replicates the sign bit
    do_load(16'h8001);
    do_start(3'd2, 4'd3, 1'b0);
    run_to_end(20, c);
    chk("sra_cycles", 32'(c), 32'd3);
    chk("sra_dout", 32'(bus.Dout), 32'hF000);
    chk("sra_sout", 32'(bus.sout), 32'h0);
    chk("sra_done", 32'(bus.done), 32'h1);

    // ROL by 15, then ROR by 1 issued in the done cycle
    do_load(16'h0001);
    do_start(3'd3, 4'd15, 1'b0);
    run_to_end(30, c);
    chk("rol_cycles", 32'(c), 32'd15);
    chk("rol_dout", 32'(bus.Dout), 32'h8000);
    do_start(3'd4, 4'd1, 1'b0);
    run_to_end(10, c);
    chk("ror_cycles", 32'(c), 32'd1);
    chk("ror_dout", 32'(bus.Dout), 32'h4000);
    chk("ror_sout", 32'(bus.sout), 32'h0);

    // SRL by 8, clear during the third busy cycle
    do_load(16'hFFFF);
    do_start(3'd1, 4'd8, 1'b0);
    step();
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_dout", 32'(bus.Dout), 32'h0);
    chk("clr_busy", 32'(bus.busy), 32'h0);
    dn = 32'(bus.done);
    for (int i = 0; i < 10; i++) begin
      step();
      dn += 32'(bus.done);
    end
    chk("clr_no_done", 32'(dn), 32'd0);

    // amt == 0 completes on the next edge with data unchanged
    do_load(16'h1234);
    do_start(3'd0, 4'd0, 1'b0);
    chk("zero_done", 32'(bus.done), 32'h1);
    chk("zero_dout", 32'(bus.Dout), 32'h1234);
    chk("zero_busy", 32'(bus.busy), 32'h0);
    step();
    chk("zero_done_pulse", 32'(bus.done), 32'h0);

    // start during SHIFT is ignored
    do_start(3'd0, 4'd5, 1'b1);
    step();
    bus.start = 1'b1;
    bus.mode  = 3'd4;
    bus.amt   = 4'd1;
    step();
    bus.start = 1'b0;
    run_to_end(20, c);
    chk("ign_cycles", 32'(c + 2), 32'd5);
    chk("ign_dout", 32'(bus.Dout), 32'h469F);
    chk("ign_sout", 32'(bus.sout), 32'h0);
    step();

    // reserved mode is ignored
    do_start(3'd6, 4'd3, 1'b0);
    chk("rsv_busy", 32'(bus.busy), 32'h0);
    chk("rsv_done", 32'(bus.done), 32'h0);
    chk("rsv_dout", 32'(bus.Dout), 32'h469F);
    step();
    chk("rsv_done2", 32'(bus.done), 32'h0);

    // asynchronous reset mid-shift
    do_start(3'd3, 4'd10, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(bus.Dout), 32'h0);
    chk("arst_sout", 32'(bus.sout), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    step();
    chk("arst_idle", 32'(bus.busy), 32'h0);
    chk("arst_dout2", 32'(bus.Dout), 32'h0);

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      r           = int'($urandom_range(0, 99));
      bus.clear   = (r < 2);
      bus.load    = (r >= 2 && r < 10);
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.mode    = 3'($urandom_range(0, 7));
      bus.amt     = 4'($urandom_range(0, 15));
      bus.shiftin = 1'($urandom);
      bus.Din     = 16'($urandom);
      step();
    end
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_shift_reg
`default_nettype wire
